// File: rtl/tone_detector_pkg.sv
// Shared types and helpers for the tone detector: FSM state encoding and
// the saturating rectifier used by the envelope follower.
package tone_detector_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        DETECTED  = 2'd2,
        RELEASING = 2'd3
    } state_t;

    // |x| clipped to DATA_W-1 bits; only the most negative code needs the clip.
    function automatic logic [DATA_W-2:0] sat_abs(input logic signed [DATA_W-1:0] x);
        logic [DATA_W-1:0] mag;
        mag = x[DATA_W-1] ? -x : x;
        if (mag[DATA_W-1]) begin
            return '1;
        end
        return mag[DATA_W-2:0];
    endfunction

endpackage

// File: rtl/envelope_follower.sv
// Rectify-then-envelope: instant attack to the rectified sample, otherwise a
// shift-based exponential decay that always makes progress down to zero.
module envelope_follower #(
    parameter int DATA_W      = tone_detector_pkg::DATA_W,
    parameter int DECAY_SHIFT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] d,
    output logic        [DATA_W-1:0] env
);
    import tone_detector_pkg::*;

    logic [DATA_W-2:0] abs_r;
    logic [DATA_W-1:0] abs_ext;
    logic [DATA_W-1:0] dec;

    assign abs_ext = {1'b0, abs_r};

    // Minimum decrement of one keeps small envelopes from stalling above zero.
    always_comb begin
        dec = env >> DECAY_SHIFT;
        if ((dec == '0) && (env != '0)) begin
            dec = DATA_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            abs_r <= '0;
            env   <= '0;
        end else begin
            abs_r <= sat_abs(d);
            if (abs_ext > env) begin
                env <= abs_ext;
            end else begin
                env <= env - dec;
            end
        end
    end

endmodule

// File: rtl/tone_detector.sv
// Envelope-based tone detector: hysteretic qualify/release FSM on the
// registered envelope, one-cycle onset pulse and peak-envelope capture.
module tone_detector #(
    parameter int DATA_W      = tone_detector_pkg::DATA_W,
    parameter int ON_THRESH   = 8192,
    parameter int OFF_THRESH  = 4096,
    parameter int DECAY_SHIFT = 4,
    parameter int ON_COUNT    = 64,
    parameter int OFF_COUNT   = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] d,
    output logic        [DATA_W-1:0] env,
    output logic                     detected,
    output logic                     onset,
    output logic        [DATA_W-1:0] peak
);
    import tone_detector_pkg::*;

    localparam int MAX_COUNT = (ON_COUNT > OFF_COUNT) ? ON_COUNT : OFF_COUNT;
    localparam int CW        = $clog2(MAX_COUNT + 1);

    localparam logic [DATA_W-1:0] ON_LVL  = DATA_W'(ON_THRESH);
    localparam logic [DATA_W-1:0] OFF_LVL = DATA_W'(OFF_THRESH);
    localparam logic [CW-1:0]     ON_END  = CW'(ON_COUNT);
    localparam logic [CW-1:0]     OFF_END = CW'(OFF_COUNT);

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nx;
    logic [CW-1:0]   cnt_inc;
    logic            onset_nx;
    logic            env_on;
    logic            env_low;

    envelope_follower #(
        .DATA_W      (DATA_W),
        .DECAY_SHIFT (DECAY_SHIFT)
    ) u_env (
        .clk   (clk),
        .reset (reset),
        .d     (d),
        .env   (env)
    );

    assign env_on   = (env >= ON_LVL);
    assign env_low  = (env < OFF_LVL);
    assign cnt_inc  = cnt + CW'(1);
    assign detected = (state == DETECTED) || (state == RELEASING);

    // cnt holds the number of consecutive qualifying evaluations so far.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        onset_nx = 1'b0;
        unique case (state)
            IDLE: begin
                if (env_on) begin
                    if (ON_COUNT == 1) begin
                        state_nx = DETECTED;
                        cnt_nx   = '0;
                        onset_nx = 1'b1;
                    end else begin
                        state_nx = ARMING;
                        cnt_nx   = CW'(1);
                    end
                end
            end
            ARMING: begin
                if (!env_on) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt_inc == ON_END) begin
                    state_nx = DETECTED;
                    cnt_nx   = '0;
                    onset_nx = 1'b1;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            DETECTED: begin
                if (env_low) begin
                    if (OFF_COUNT == 1) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end else begin
                        state_nx = RELEASING;
                        cnt_nx   = CW'(1);
                    end
                end
            end
            RELEASING: begin
                if (!env_low) begin
                    state_nx = DETECTED;
                    cnt_nx   = '0;
                end else if (cnt_inc == OFF_END) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            onset <= 1'b0;
            peak  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            onset <= onset_nx;
            if (onset_nx) begin
                peak <= env;
            end else if (detected && (env > peak)) begin
                peak <= env;
            end
        end
    end

endmodule

// File: tb/tb_tone_detector.sv
// Bench for tone_detector: directed scenarios with literal expectations plus
// a randomized run, all outputs compared every cycle against a run-length model.
module tb_tone_detector;

    localparam int DATA_W      = 16;
    localparam int ON_THRESH   = 8192;
    localparam int OFF_THRESH  = 4096;
    localparam int DECAY_SHIFT = 4;
    localparam int ON_COUNT    = 64;
    localparam int OFF_COUNT   = 256;
    localparam int W           = 34;

    logic                     clk;
    logic                     reset;
    logic signed [DATA_W-1:0] d;
    logic        [DATA_W-1:0] env;
    logic                     detected;
    logic                     onset;
    logic        [DATA_W-1:0] peak;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];

    int m_abs  = 0;
    int m_env  = 0;
    int m_peak = 0;
    int m_run  = 0;
    int m_rel  = 0;
    bit m_det  = 1'b0;
    bit m_on   = 1'b0;

    tone_detector #(
        .DATA_W      (DATA_W),
        .ON_THRESH   (ON_THRESH),
        .OFF_THRESH  (OFF_THRESH),
        .DECAY_SHIFT (DECAY_SHIFT),
        .ON_COUNT    (ON_COUNT),
        .OFF_COUNT   (OFF_COUNT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .d        (d),
        .env      (env),
        .detected (detected),
        .onset    (onset),
        .peak     (peak)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking helper ----------------
    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Detection = ON_COUNT consecutive evaluations at or above ON_THRESH while
    // not detected; release = OFF_COUNT consecutive evaluations below OFF_THRESH.
    task automatic model_reset();
        m_abs  = 0;
        m_env  = 0;
        m_peak = 0;
        m_run  = 0;
        m_rel  = 0;
        m_det  = 1'b0;
        m_on   = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_step();
        int e_old;
        int di;
        int dec;
        bit rise;
        bit fall;
        logic [W-1:0] e;
        e_old = m_env;
        rise  = 1'b0;
        fall  = 1'b0;
        if (!m_det) begin
            m_run = (e_old >= ON_THRESH) ? m_run + 1 : 0;
            if (m_run == ON_COUNT) begin
                rise  = 1'b1;
                m_run = 0;
            end
        end else begin
            m_rel = (e_old < OFF_THRESH) ? m_rel + 1 : 0;
            if (m_rel == OFF_COUNT) begin
                fall  = 1'b1;
                m_rel = 0;
            end
        end
        if (rise) m_peak = e_old;
        else if (m_det && (e_old > m_peak)) m_peak = e_old;
        if (rise) m_det = 1'b1;
        else if (fall) m_det = 1'b0;
        m_on = rise;
        dec = e_old / (1 << DECAY_SHIFT);
        if (dec == 0 && e_old != 0) dec = 1;
        m_env = (m_abs > e_old) ? m_abs : e_old - dec;
        di = d;
        m_abs = (di == -32768) ? 32767 : ((di < 0) ? -di : di);
        e = {m_env[15:0], m_det, m_on, m_peak[15:0]};
        exp_q.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    // ---------------- scoreboard compare ----------------
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_env", env, 0);
                chk("rst_detected", detected, 0);
                chk("rst_onset", onset, 0);
                chk("rst_peak", peak, 0);
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("env", env, e[33:18]);
                chk("detected", detected, e[17]);
                chk("onset", onset, e[16]);
                chk("peak", peak, e[15:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input logic signed [DATA_W-1:0] v);
        d = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        d = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic signed [DATA_W-1:0] rnd_sample(input int mode);
        int a;
        case (mode)
            0:       a = 0;
            1:       a = $urandom_range(0, 3000);
            2:       a = $urandom_range(9000, 32767);
            default: a = $urandom_range(0, 32767);
        endcase
        if ($urandom_range(0, 1) == 1) a = -a;
        if (mode >= 2 && $urandom_range(0, 40) == 0) a = -32768;
        return DATA_W'(a);
    endfunction

    // ---------------- directed + random stimulus ----------------
    initial begin
        int n;
        bit bad;
        reset = 1'b1;
        d = 16'sh7FFF;
        repeat (3) @(posedge clk);
        #1;
        chk("hold_rst_env", env, 0);
        chk("hold_rst_detected", detected, 0);
        chk("hold_rst_onset", onset, 0);
        chk("hold_rst_peak", peak, 0);
        @(negedge clk);
        #1;
        reset = 1'b0;

        // Saturation of the most negative code and the first decay step.
        tick(16'sh8000);
        tick(16'sh0000);
        chk("sat_env", env, 32767);
        tick(16'sh0000);
        chk("sat_decay", env, 30720);
        do_reset();

        // Decay floor from 5.
        tick(16'sh0005);
        tick(16'sh0000);
        chk("floor_5", env, 5);
        for (int v = 4; v >= 0; v--) begin
            tick(16'sh0000);
            chk("floor_step", env, v);
        end
        tick(16'sh0000);
        chk("floor_hold", env, 0);
        do_reset();

        // Step attack: edges 0..65 carry full scale.
        for (int i = 0; i <= 65; i++) begin
            tick(16'sh7FFF);
            if (i == 64) chk("step_not_yet", detected, 0);
        end
        chk("step_detected", detected, 1);
        chk("step_onset", onset, 1);
        tick(16'sh7FFF);
        chk("step_onset_low", onset, 0);
        chk("step_still_det", detected, 1);
        chk("step_peak", peak, 32767);

        // Release with a hysteresis re-trigger while releasing.
        n = 0;
        while (env >= 16'd4096 && n < 200) begin
            tick(16'sh0000);
            n++;
        end
        chk("release_decay_in_time", (n < 200) ? 1 : 0, 1);
        repeat (5) tick(16'sh0000);
        chk("releasing_det", detected, 1);
        for (int i = 0; i < 3; i++) begin
            tick(16'sh7FFF);
            chk("retrigger_det", detected, 1);
            chk("retrigger_no_onset", onset, 0);
        end
        n = 0;
        tick(16'sh0000);
        while (env >= 16'd4096 && n < 200) begin
            tick(16'sh0000);
            n++;
        end
        chk("release2_decay_in_time", (n < 200) ? 1 : 0, 1);
        repeat (255) tick(16'sh0000);
        chk("release_det_at_255", detected, 1);
        tick(16'sh0000);
        chk("release_det_at_256", detected, 0);
        chk("release_peak_held", peak, 32767);
        chk("release_onset", onset, 0);

        // Impulse rejection.
        do_reset();
        tick(16'sh7FFF);
        bad = 1'b0;
        for (int i = 0; i < 70; i++) begin
            tick(16'sh0000);
            if (detected || onset) bad = 1'b1;
            if (i == 40) chk("impulse_env_low", (env < 16'd8192) ? 1 : 0, 1);
        end
        chk("impulse_no_detect", bad, 0);

        // Asynchronous reset in the middle of a detection.
        do_reset();
        repeat (70) tick(16'sh7FFF);
        chk("async_pre_det", detected, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_env", env, 0);
        chk("async_detected", detected, 0);
        chk("async_onset", onset, 0);
        chk("async_peak", peak, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b0;

        // Randomized segments of quiet, loud and mixed signal.
        for (int seg = 0; seg < 20; seg++) begin
            int mode;
            int len;
            mode = $urandom_range(0, 3);
            len  = $urandom_range(1, 400);
            if (seg == 10) do_reset();
            for (int i = 0; i < len; i++) tick(rnd_sample(mode));
        end
        repeat (3) tick(16'sh0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tone_detector.md
# tone_detector

Envelope-follower tone detector that sits directly downstream of `digital_resonator`. It takes the resonator's signed 16-bit output one sample per clock, rectifies it, and tracks a peak-hold/exponential-decay envelope. A hysteretic qualify/release state machine then asserts `detected` while the resonator is ringing at its centre frequency. It also reports a one-cycle `onset` pulse and the peak envelope of the current or most recent detection.

## Interface
- `DATA_W`, 16, sample width; `d` is signed, `env` and `peak` are unsigned.
- `ON_THRESH`, 8192, envelope level at or above which a sample qualifies for attack.
- `OFF_THRESH`, 4096, envelope level below which a sample qualifies for release. Must satisfy `OFF_THRESH < ON_THRESH <= 2**(DATA_W-1)-1`.
- `DECAY_SHIFT`, 4, envelope decay per cycle is `env >> DECAY_SHIFT`.
- `ON_COUNT`, 64, consecutive qualifying cycles needed to declare detection (>=1).
- `OFF_COUNT`, 256, consecutive qualifying cycles needed to release (>=1).

Ports:
- `clk`, in, 1, single clock; one sample per rising edge.
- `reset`, in, 1. Reset is asynchronous and active-high. All registers clear on assertion without waiting for a clock edge.
- `d`, in, DATA_W, signed sample, driven directly by resonator `q`.
- `env`, out, DATA_W, unsigned envelope, registered.
- `detected`, out, 1, high in DETECTED and RELEASING states.
- `onset`, out, 1, one-cycle pulse on each entry to DETECTED from ARMING or IDLE.
- `peak`, out, DATA_W, max `env` since last onset; held after release.

## Operation
- **Reset values.** `env=0`, `detected=0`, `onset=0`, `peak=0`, state IDLE, counter 0.
- **Stage 1, rectify.** `abs_r <= |d|` with saturation: -32768 maps to 32767. Result is DATA_W-1 significant bits.
- **Stage 2, envelope.**
  - If `abs_r > env`, then `env <= abs_r` (instant attack).
  - Otherwise `env <= env - dec`, where `dec = env >> DECAY_SHIFT`.
  - If `dec==0` and `env!=0`, then `dec=1`, so the envelope reaches 0 and never underflows.
- **FSM.** States are IDLE, ARMING, DETECTED, RELEASING. Counter width is `$clog2(max(ON_COUNT,OFF_COUNT)+1)`.
  - **IDLE:**
    - If `env>=ON_THRESH` and `ON_COUNT==1`, go to DETECTED.
    - Else if `env>=ON_THRESH`, go to ARMING with cnt=1.
  - **ARMING:**
    - If `env<ON_THRESH`, go to IDLE with cnt=0.
    - Else cnt++. When cnt+1 reaches ON_COUNT, go to DETECTED and pulse `onset`.
  - **DETECTED:**
    - If `env<OFF_THRESH`, go to RELEASING with cnt=1.
    - If `OFF_COUNT==1`, go straight to IDLE instead.
  - **RELEASING:**
    - If `env>=OFF_THRESH`, return to DETECTED with cnt=0 and no onset.
    - Else cnt++. When cnt+1 reaches OFF_COUNT, go to IDLE.
- **Peak.** On the onset cycle, `peak <= env`. While `detected`, `peak <= max(peak, env)`. Otherwise `peak` holds.
- **Simultaneous events.** Reset dominates everything. Threshold comparisons use the registered `env`, never `abs_r`.

## Timing
- `d` sampled at edge k appears in `abs_r` after edge k and in `env` after edge k+1.
- With a step that qualifies from its first sample at edge 0, `detected` and `onset` rise after edge `ON_COUNT+1`. `onset` falls after the next edge.
- Release: `detected` falls after the edge that evaluates the OFF_COUNT-th consecutive `env<OFF_THRESH`.
- Throughput is one sample per clock with no stalls and no backpressure.
- Reset mid-operation (any state): outputs go to their reset values asynchronously. After deassertion, the first sample is processed normally with no partial counts retained.

## Structure
- Package `tone_detector_pkg` holds:
  - `state_t` enum (IDLE, ARMING, DETECTED, RELEASING)
  - `DATA_W` default
  - function `sat_abs(logic signed [DATA_W-1:0])`
- Sub-module `envelope_follower` contains stages 1–2 (clk, reset, d, env, parameter DECAY_SHIFT). The top level holds the FSM, counter and peak register.

## Test plan
- **Reset.** Hold `reset` with `d=16'sh7FFF` → `env`, `detected`, `onset`, `peak` all 0. Assert `reset` asynchronously mid-DETECTED → all outputs 0 before the next edge.
- **Saturation.** A single sample `d=-32768` at edge 0 → `env==32767` after edge 1, followed by decay 32767→30720 (−2047) on the next cycle.
- **Step attack.** `d=16'sh7FFF` held from edge 0 → `detected` and `onset` high after edge 65. `onset` is low again after edge 66. `peak==32767`.
- **Impulse rejection.** `d=16'sh7FFF` for one cycle, then 0 → `env` drops below 8192 in roughly 22 cycles (<64), FSM returns to IDLE, and `detected`/`onset` never assert.
- **Release with hysteresis.** After detection, `d=0` → `env` falls below 4096 about 33 cycles later. Reapply `16'sh7FFF` while RELEASING → `detected` stays high with no `onset`. Then hold `d=0` → `detected` falls exactly 256 evaluations after the first sub-4096 `env`, and `peak` still reads 32767.
- **Decay floor.** Load `env=5`, then `d=0` → `env` steps 5,4,3,2,1,0 and remains 0.
